line_buffer_responder: RTL and testbench



---
 rtl/line_buffer_responder.sv | 215 +++++++++++++++++++++
 tb/tb_line_buffer_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_responder.sv
// line_buffer_responder: LC-3b 16-bit memory port backed by 128-bit line memory.
// Define LINE_BUF_HIT_EN to answer reads from the buffered line without pmem traffic.
module line_buffer_responder (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_byte_enable,
    input  logic [15:0]  mem_address,
    input  logic [15:0]  mem_wdata,
    output logic         mem_resp,
    output logic [15:0]  mem_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic         pmem_resp,
    input  logic [127:0] pmem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_MERGE_WR,
        S_RESP
    } state_e;

    state_e state_q, state_d;

    logic         line_valid_q, line_valid_d;
    logic [11:0]  line_tag_q, line_tag_d;
    logic [127:0] line_data_q, line_data_d;

    logic         req_write_q, req_write_d;
    logic [15:1]  req_addr_q, req_addr_d;
    logic [15:0]  req_wdata_q, req_wdata_d;
    logic [1:0]   req_be_q, req_be_d;

    logic         mem_resp_q, mem_resp_d;
    logic [15:0]  mem_rdata_q, mem_rdata_d;
    logic         pmem_read_q, pmem_read_d;
    logic         pmem_write_q, pmem_write_d;
    logic [15:0]  pmem_addr_q, pmem_addr_d;
    logic [127:0] pmem_wdata_q, pmem_wdata_d;

    // Operand view: live inputs while idle, captured copy afterwards.
    logic         is_idle;
    logic         op_write;
    logic [11:0]  op_tag;
    logic [2:0]   op_idx;
    logic [1:0]   op_be;
    logic [15:0]  op_wdata;
    logic         tag_match;
    logic         hit;
    logic [127:0] merged_buf;
    logic [127:0] merged_fill;
    logic         unused_ok;

    function automatic logic [15:0] word_sel(
        input logic [127:0] line,
        input logic [2:0]   idx
    );
        return line[{idx, 4'h0} +: 16];
    endfunction

    function automatic logic [127:0] merge_word(
        input logic [127:0] line,
        input logic [2:0]   idx,
        input logic [1:0]   be,
        input logic [15:0]  wdata
    );
        logic [127:0] res;
        res = line;
        if (be[0]) res[{idx, 4'h0} +: 8] = wdata[7:0];
        if (be[1]) res[{idx, 4'h8} +: 8] = wdata[15:8];
        return res;
    endfunction

    assign is_idle  = (state_q == S_IDLE);
    assign op_write = is_idle ? mem_write : req_write_q;
    assign op_tag   = is_idle ? mem_address[15:4] : req_addr_q[15:4];
    assign op_idx   = is_idle ? mem_address[3:1] : req_addr_q[3:1];
    assign op_be    = is_idle ? mem_byte_enable : req_be_q;
    assign op_wdata = is_idle ? mem_wdata : req_wdata_q;

    assign tag_match   = (line_tag_q == op_tag);
    assign merged_buf  = merge_word(line_data_q, op_idx, op_be, op_wdata);
    assign merged_fill = merge_word(pmem_rdata, op_idx, op_be, op_wdata);

`ifdef LINE_BUF_HIT_EN
    assign hit       = line_valid_q && tag_match;
    assign unused_ok = mem_address[0];
`else
    // Buffer is only a staging register; valid/tag are kept but never trusted.
    assign hit       = 1'b0;
    assign unused_ok = ^{mem_address[0], line_valid_q, tag_match};
`endif

    // Next-state and next-output decode for the request FSM.
    always_comb begin
        state_d      = state_q;
        line_valid_d = line_valid_q;
        line_tag_d   = line_tag_q;
        line_data_d  = line_data_q;
        req_write_d  = req_write_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        req_be_d     = req_be_q;
        mem_resp_d   = 1'b0;
        mem_rdata_d  = '0;
        pmem_read_d  = pmem_read_q;
        pmem_write_d = pmem_write_q;
        pmem_addr_d  = pmem_addr_q;
        pmem_wdata_d = pmem_wdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (mem_read || mem_write) begin
                    req_write_d = mem_write;
                    req_addr_d  = mem_address[15:1];
                    req_wdata_d = mem_wdata;
                    req_be_d    = mem_byte_enable;
                    pmem_addr_d = {op_tag, 4'h0};
                    if (hit && op_write) begin
                        line_data_d  = merged_buf;
                        pmem_write_d = 1'b1;
                        pmem_wdata_d = merged_buf;
                        state_d      = S_MERGE_WR;
                    end else if (hit) begin
                        mem_resp_d  = 1'b1;
                        mem_rdata_d = word_sel(line_data_q, op_idx);
                        state_d     = S_RESP;
                    end else begin
                        pmem_read_d = 1'b1;
                        state_d     = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (pmem_resp) begin
                    pmem_read_d  = 1'b0;
                    line_valid_d = 1'b1;
                    line_tag_d   = op_tag;
                    if (op_write) begin
                        line_data_d  = merged_fill;
                        pmem_write_d = 1'b1;
                        pmem_wdata_d = merged_fill;
                        state_d      = S_MERGE_WR;
                    end else begin
                        line_data_d = pmem_rdata;
                        mem_resp_d  = 1'b1;
                        mem_rdata_d = word_sel(pmem_rdata, op_idx);
                        state_d     = S_RESP;
                    end
                end
            end
            S_MERGE_WR: begin
                if (pmem_resp) begin
                    pmem_write_d = 1'b0;
                    mem_resp_d   = 1'b1;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, line buffer and registered outputs; reset aborts any transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            line_valid_q <= 1'b0;
            line_tag_q   <= '0;
            line_data_q  <= '0;
            req_write_q  <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            req_be_q     <= '0;
            mem_resp_q   <= 1'b0;
            mem_rdata_q  <= '0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            pmem_addr_q  <= '0;
            pmem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            line_valid_q <= line_valid_d;
            line_tag_q   <= line_tag_d;
            line_data_q  <= line_data_d;
            req_write_q  <= req_write_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            req_be_q     <= req_be_d;
            mem_resp_q   <= mem_resp_d;
            mem_rdata_q  <= mem_rdata_d;
            pmem_read_q  <= pmem_read_d;
            pmem_write_q <= pmem_write_d;
            pmem_addr_q  <= pmem_addr_d;
            pmem_wdata_q <= pmem_wdata_d;
        end
    end

    assign mem_resp     = mem_resp_q;
    assign mem_rdata    = mem_rdata_q;
    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = pmem_addr_q;
    assign pmem_wdata   = pmem_wdata_q;

endmodule

// File: tb/tb_line_buffer_responder.sv
// tb_line_buffer_responder: directed bench for line_buffer_responder.
// Expectations follow LINE_BUF_HIT_EN if the bench is built with it.
module tb_line_buffer_responder;

`ifdef LINE_BUF_HIT_EN
    localparam bit HIT_EN = 1'b1;
`else
    localparam bit HIT_EN = 1'b0;
`endif

    localparam logic [127:0] LINE100 = {16'h7777, 16'h6666, 16'h5555, 16'h4444,
                                        16'h3333, 16'h5566, 16'hBEEF, 16'h1111};
    localparam logic [127:0] LINE100_WR = {16'h7777, 16'h6666, 16'h5555, 16'h4444,
                                           16'h3333, 16'h1266, 16'hBEEF, 16'h1111};
    localparam logic [127:0] LINE200 = {8{16'hAAAA}};
    localparam logic [127:0] LINE200_WR = {{7{16'hAAAA}}, 16'hCAFE};
    localparam logic [127:0] LINE300 = {8{16'h0F0F}};
    localparam logic [127:0] LINE300_WR = {{7{16'h0F0F}}, 16'h1234};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mem_read, mem_write;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_address, mem_wdata;
    logic         mem_resp;
    logic [15:0]  mem_rdata;
    logic         pmem_read, pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;

    logic [127:0] pm [logic [11:0]];
    int lat, cnt, n_rd, n_wr, overlap, resp_cnt;
    int checks = 0;
    int errors = 0;
    logic [15:0]  last_rd_addr, last_wr_addr;
    logic [127:0] last_wdata;

    always #5 clk = ~clk;

    line_buffer_responder dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Count completion pulses away from the active edge.
    always @(negedge clk) if (mem_resp === 1'b1) resp_cnt++;

    // Line memory model: answers each strobe after lat waiting cycles.
    initial begin
        logic [11:0] a;
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                pmem_resp = 1'b0;
                cnt = 0;
            end else begin
                if (pmem_read && pmem_write) overlap++;
                if (pmem_resp) begin
                    pmem_resp = 1'b0;
                    cnt = 0;
                end
                if (pmem_read || pmem_write) begin
                    if (cnt >= lat) begin
                        a = pmem_address[15:4];
                        pmem_resp = 1'b1;
                        if (pmem_read) begin
                            n_rd++;
                            last_rd_addr = pmem_address;
                            pmem_rdata = pm.exists(a) ? pm[a] : '0;
                        end
                        if (pmem_write) begin
                            n_wr++;
                            last_wr_addr = pmem_address;
                            last_wdata = pmem_wdata;
                            pm[a] = pmem_wdata;
                        end
                        cnt = 0;
                    end else begin
                        cnt++;
                    end
                end
            end
        end
    end

    task automatic do_req(input logic rd, input logic wr,
                          input logic [15:0] addr, input logic [1:0] be,
                          input logic [15:0] wd,
                          output logic [15:0] rdata, output int cyc);
        mem_read = rd;
        mem_write = wr;
        mem_address = addr;
        mem_byte_enable = be;
        mem_wdata = wd;
        cyc = 0;
        while (cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (mem_resp) break;
        end
        chk("resp_seen", {127'b0, mem_resp}, 128'd1);
        rdata = mem_rdata;
        mem_read = 1'b0;
        mem_write = 1'b0;
        @(posedge clk);
        #1;
        chk("resp_pulse", {127'b0, mem_resp}, 128'd0);
    endtask

    initial begin
        logic [15:0] rd;
        int cyc, r0, w0, c0;
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [15:0] rd;
        int cyc, r0, w0, c0;
        n_rd = 0; n_wr = 0; overlap = 0; resp_cnt = 0;
        last_rd_addr = '0; last_wr_addr = '0; last_wdata = '0;
        lat = 3;
        pm[12'h100] = LINE100;
        pm[12'h200] = LINE200;
        pm[12'h300] = LINE300;
        rst_n = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0;
        mem_byte_enable = 2'b00; mem_address = '0; mem_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_resp", {127'b0, mem_resp}, 128'd0);
        chk("rst_mem_rdata", {112'b0, mem_rdata}, 128'd0);
        chk("rst_pmem_read", {127'b0, pmem_read}, 128'd0);
        chk("rst_pmem_write", {127'b0, pmem_write}, 128'd0);
        chk("rst_pmem_addr", {112'b0, pmem_address}, 128'd0);
        chk("rst_pmem_wdata", pmem_wdata, 128'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // read miss, 3-cycle line latency
        r0 = n_rd;
        do_req(1'b1, 1'b0, 16'h1002, 2'b00, 16'h0, rd, cyc);
        chk("rmiss_data", {112'b0, rd}, {112'b0, 16'hBEEF});
        chk("rmiss_nrd", n_rd - r0, 1);
        chk("rmiss_addr", {112'b0, last_rd_addr}, {112'b0, 16'h1000});
        chk("rmiss_cyc", cyc, 5);

        // read of the same line
        r0 = n_rd;
        do_req(1'b1, 1'b0, 16'h100E, 2'b00, 16'h0, rd, cyc);
        chk("rhit_data", {112'b0, rd}, {112'b0, 16'h7777});
        chk("rhit_nrd", n_rd - r0, HIT_EN ? 0 : 1);
        chk("rhit_cyc", cyc, HIT_EN ? 1 : 5);

        // high-byte write on buffered line
        r0 = n_rd; w0 = n_wr;
        do_req(1'b0, 1'b1, 16'h1004, 2'b10, 16'h12AB, rd, cyc);
        chk("whit_nwr", n_wr - w0, 1);
        chk("whit_nrd", n_rd - r0, HIT_EN ? 0 : 1);
        chk("whit_line", last_wdata, LINE100_WR);
        chk("whit_waddr", {112'b0, last_wr_addr}, {112'b0, 16'h1000});
        chk("whit_rdata", {112'b0, rd}, 128'd0);
        chk("whit_cyc", cyc, HIT_EN ? 5 : 9);

        // write miss, zero-latency responses
        lat = 0;
        r0 = n_rd; w0 = n_wr;
        do_req(1'b0, 1'b1, 16'h2000, 2'b11, 16'hCAFE, rd, cyc);
        chk("wmiss_nrd", n_rd - r0, 1);
        chk("wmiss_raddr", {112'b0, last_rd_addr}, {112'b0, 16'h2000});
        chk("wmiss_nwr", n_wr - w0, 1);
        chk("wmiss_line", last_wdata, LINE200_WR);
        chk("wmiss_cyc", cyc, 3);

        // read back written word
        r0 = n_rd;
        do_req(1'b1, 1'b0, 16'h2000, 2'b00, 16'h0, rd, cyc);
        chk("rback_data", {112'b0, rd}, {112'b0, 16'hCAFE});
        chk("rback_nrd", n_rd - r0, HIT_EN ? 0 : 1);
        chk("rback_cyc", cyc, HIT_EN ? 1 : 2);

        // read and write together: write wins
        r0 = n_rd; w0 = n_wr;
        do_req(1'b1, 1'b1, 16'h3000, 2'b11, 16'h1234, rd, cyc);
        chk("both_rdata", {112'b0, rd}, 128'd0);
        chk("both_nwr", n_wr - w0, 1);
        chk("both_nrd", n_rd - r0, 1);
        chk("both_line", last_wdata, LINE300_WR);
        chk("both_cyc", cyc, 3);

        // empty byte enable still writes the line unchanged
        r0 = n_rd; w0 = n_wr;
        do_req(1'b0, 1'b1, 16'h3002, 2'b00, 16'hFFFF, rd, cyc);
        chk("be0_nwr", n_wr - w0, 1);
        chk("be0_line", last_wdata, LINE300_WR);
        chk("be0_nrd", n_rd - r0, HIT_EN ? 0 : 1);
        chk("be0_cyc", cyc, HIT_EN ? 2 : 3);

        // reset during a pending fetch
        lat = 10;
        mem_read = 1'b1;
        mem_address = 16'h1008;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("abort_strobe_up", {127'b0, pmem_read}, 128'd1);
        c0 = resp_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_strobe_drop", {127'b0, pmem_read}, 128'd0);
        mem_read = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("abort_no_resp", resp_cnt - c0, 0);
        chk("abort_idle_strobe", {127'b0, pmem_read}, 128'd0);

        lat = 1;
        r0 = n_rd;
        do_req(1'b1, 1'b0, 16'h1008, 2'b00, 16'h0, rd, cyc);
        chk("refetch_data", {112'b0, rd}, {112'b0, 16'h4444});
        chk("refetch_nrd", n_rd - r0, 1);
        chk("refetch_addr", {112'b0, last_rd_addr}, {112'b0, 16'h1000});
        chk("refetch_cyc", cyc, 3);

        chk("no_overlap", overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
